// File: rtl/run_chk_pkg.sv
// Shared types for the end-of-program run checker.
//   run_state_t : checker FSM states.
//   chk_rec_t   : per-channel record (seen / sticky mismatch / last written data).
// The record's data field is sized for the widest supported write data; channels
// zero-extend narrower data into it.
package run_chk_pkg;

  localparam int unsigned MaxDataW = 64;

  typedef enum logic [2:0] {
    IDLE,
    RUN,
    PASS,
    FAIL,
    TIMEOUT
  } run_state_t;

  typedef struct packed {
    logic                seen;
    logic                mismatch;
    logic [MaxDataW-1:0] last;
  } chk_rec_t;

endpackage

// File: rtl/run_chk_channel.sv
// One check channel: tracks writes to a single expected address and reports
// whether the channel would pass or fail if the run ended this cycle.
// Ports:
//   clk_i, rst_ni      clock, asynchronous active-low reset
//   clr_i              clear the record (checker idle)
//   upd_i              fold this cycle's hit into the record (checker running)
//   en_i, strict_i     channel enable, strict (any wrong-data write fails)
//   mem_write_i        core write strobe
//   data_adr_i         core write address
//   write_data_i       core write data
//   addr_i, data_i     expected address and final data
//   pass_now_o         enabled and passing, including this cycle's write
//   fail_now_o         enabled and failing, including this cycle's write
module run_chk_channel
  import run_chk_pkg::*;
#(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              clr_i,
  input  logic              upd_i,
  input  logic              en_i,
  input  logic              strict_i,
  input  logic              mem_write_i,
  input  logic [ADDR_W-1:0] data_adr_i,
  input  logic [DATA_W-1:0] write_data_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [DATA_W-1:0] data_i,
  output logic              pass_now_o,
  output logic              fail_now_o
);

  chk_rec_t            rec_q, rec_d, rec_now;
  logic                hit;
  logic [MaxDataW-1:0] wdata_ext, exp_ext;

  assign wdata_ext = MaxDataW'(write_data_i);
  assign exp_ext   = MaxDataW'(data_i);
  assign hit       = mem_write_i && en_i && (data_adr_i == addr_i);

  // Record as it would stand after this cycle's write; the verdict uses this
  // so a write coinciding with the end condition is not lost.
  always_comb begin
    rec_now = rec_q;
    if (hit) begin
      rec_now.seen = 1'b1;
      rec_now.last = wdata_ext;
      if (strict_i && (wdata_ext != exp_ext)) begin
        rec_now.mismatch = 1'b1;
      end
    end
  end

  always_comb begin
    fail_now_o = en_i && (!rec_now.seen || (rec_now.last != exp_ext) || rec_now.mismatch);
    pass_now_o = en_i && !fail_now_o;
  end

  always_comb begin
    rec_d = rec_q;
    if (clr_i) begin
      rec_d = '0;
    end else if (upd_i) begin
      rec_d = rec_now;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rec_q <= '0;
    end else begin
      rec_q <= rec_d;
    end
  end

endmodule

// File: rtl/run_checker.sv
// End-of-program checker: arms on start, watches the core PC and data-memory
// write port, and latches PASS, FAIL or TIMEOUT once the PC word index reaches
// end_idx or the RUN cycle budget runs out.
// Ports:
//   clk, reset (async, active-low)
//   start / clear      arm from IDLE / return to IDLE (aborts a run)
//   pc                 core PC, byte address
//   mem_write, data_adr, write_data   core data-memory write port
//   end_idx            run ends when pc>>2 >= end_idx
//   timeout_cyc        RUN cycle budget, 0 disables
//   chk_en, chk_strict, chk_addr, chk_data   per-channel configuration (ch0 in LSBs)
//   done, pass, fail, timeout    registered verdict flags
//   fail_mask          failing channels, valid when done
//   cycle_count        RUN cycles elapsed, saturating
module run_checker
  import run_chk_pkg::*;
#(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned NUM_CHK = 4,
  parameter int unsigned CNT_W   = 16
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      start,
  input  logic                      clear,
  input  logic [ADDR_W-1:0]         pc,
  input  logic                      mem_write,
  input  logic [ADDR_W-1:0]         data_adr,
  input  logic [DATA_W-1:0]         write_data,
  input  logic [ADDR_W-3:0]         end_idx,
  input  logic [CNT_W-1:0]          timeout_cyc,
  input  logic [NUM_CHK-1:0]        chk_en,
  input  logic [NUM_CHK-1:0]        chk_strict,
  input  logic [NUM_CHK*ADDR_W-1:0] chk_addr,
  input  logic [NUM_CHK*DATA_W-1:0] chk_data,
  output logic                      done,
  output logic                      pass,
  output logic                      fail,
  output logic                      timeout,
  output logic [NUM_CHK-1:0]        fail_mask,
  output logic [CNT_W-1:0]          cycle_count
);

  run_state_t         state_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [NUM_CHK-1:0] mask_q;
  logic               done_q, pass_q, fail_q, tout_q;

  logic [NUM_CHK-1:0] pass_vec, fail_vec;
  logic               end_hit, tout_hit, ch_clr, ch_upd;
  logic [CNT_W:0]     cnt_inc;
  logic [CNT_W-1:0]   cnt_sat;

  assign ch_clr = (state_q == IDLE);
  assign ch_upd = (state_q == RUN);

  for (genvar c = 0; c < NUM_CHK; c++) begin : gen_chan
    run_chk_channel #(
      .ADDR_W(ADDR_W),
      .DATA_W(DATA_W)
    ) u_chan (
      .clk_i       (clk),
      .rst_ni      (reset),
      .clr_i       (ch_clr),
      .upd_i       (ch_upd),
      .en_i        (chk_en[c]),
      .strict_i    (chk_strict[c]),
      .mem_write_i (mem_write),
      .data_adr_i  (data_adr),
      .write_data_i(write_data),
      .addr_i      (chk_addr[c*ADDR_W +: ADDR_W]),
      .data_i      (chk_data[c*DATA_W +: DATA_W]),
      .pass_now_o  (pass_vec[c]),
      .fail_now_o  (fail_vec[c])
    );
  end

  assign end_hit = (pc[ADDR_W-1:2] >= end_idx);
  // One bit wider so the count including this cycle never wraps in the compare.
  assign cnt_inc  = {1'b0, cnt_q} + (CNT_W+1)'(1);
  assign cnt_sat  = (&cnt_q) ? cnt_q : cnt_inc[CNT_W-1:0];
  assign tout_hit = (timeout_cyc != '0) && (cnt_inc >= {1'b0, timeout_cyc});

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      mask_q  <= '0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
      fail_q  <= 1'b0;
      tout_q  <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          cnt_q  <= '0;
          mask_q <= '0;
          done_q <= 1'b0;
          pass_q <= 1'b0;
          fail_q <= 1'b0;
          tout_q <= 1'b0;
          if (start) begin
            state_q <= RUN;
          end
        end
        RUN: begin
          if (clear) begin
            state_q <= IDLE;
          end else begin
            cnt_q <= cnt_sat;
            if (end_hit) begin
              mask_q <= fail_vec;
              done_q <= 1'b1;
              if (|fail_vec) begin
                state_q <= FAIL;
                fail_q  <= 1'b1;
              end else begin
                state_q <= PASS;
                pass_q  <= 1'b1;
              end
            end else if (tout_hit) begin
              mask_q  <= chk_en & ~pass_vec;
              done_q  <= 1'b1;
              tout_q  <= 1'b1;
              state_q <= TIMEOUT;
            end
          end
        end
        PASS, FAIL, TIMEOUT: begin
          // Verdict held; only clear leaves (start is ignored, even with clear).
          if (clear) begin
            state_q <= IDLE;
            mask_q  <= '0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
            fail_q  <= 1'b0;
            tout_q  <= 1'b0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign done        = done_q;
  assign pass        = pass_q;
  assign fail        = fail_q;
  assign timeout     = tout_q;
  assign fail_mask   = mask_q;
  assign cycle_count = cnt_q;

endmodule
